// File: rtl/md5_iter_engine.sv
// md5_iter_engine
// Iterative MD5 over one fixed 8-byte ASCII candidate. The engine runs one
// RFC 1321 round per clock: 1 accept edge, 64 round edges, and 1 finalise edge.
//   clk      : system clock, rising edge
//   reset_n  : synchronous active-low reset
//   start    : hash request, sampled only while idle
//   txt      : candidate; txt[63:56] is the first character
//   busy     : high from the accepting edge until the done edge
//   done     : one-cycle pulse; hash is valid from this cycle onward
//   hash     : digest in printed order; hash[127:120] is digest byte 0
module md5_iter_engine (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [63:0]  txt,
   output logic         busy,
   output logic         done,
   output logic [127:0] hash
);

   localparam logic [31:0] IV_A = 32'h67452301;
   localparam logic [31:0] IV_B = 32'hefcdab89;
   localparam logic [31:0] IV_C = 32'h98badcfe;
   localparam logic [31:0] IV_D = 32'h10325476;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t       state_q, state_d;
   logic [5:0]   i_q, i_d;
   logic [31:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
   logic [31:0]  m0_q, m0_d, m1_q, m1_d;
   logic         busy_q, busy_d, done_q, done_d;
   logic [127:0] hash_q, hash_d;

   function automatic logic [31:0] k_of(input logic [5:0] n);
      logic [31:0] k;
      case (n)
         6'd0:  k = 32'hd76aa478; 6'd1:  k = 32'he8c7b756; 6'd2:  k = 32'h242070db; 6'd3:  k = 32'hc1bdceee;
         6'd4:  k = 32'hf57c0faf; 6'd5:  k = 32'h4787c62a; 6'd6:  k = 32'ha8304613; 6'd7:  k = 32'hfd469501;
         6'd8:  k = 32'h698098d8; 6'd9:  k = 32'h8b44f7af; 6'd10: k = 32'hffff5bb1; 6'd11: k = 32'h895cd7be;
         6'd12: k = 32'h6b901122; 6'd13: k = 32'hfd987193; 6'd14: k = 32'ha679438e; 6'd15: k = 32'h49b40821;
         6'd16: k = 32'hf61e2562; 6'd17: k = 32'hc040b340; 6'd18: k = 32'h265e5a51; 6'd19: k = 32'he9b6c7aa;
         6'd20: k = 32'hd62f105d; 6'd21: k = 32'h02441453; 6'd22: k = 32'hd8a1e681; 6'd23: k = 32'he7d3fbc8;
         6'd24: k = 32'h21e1cde6; 6'd25: k = 32'hc33707d6; 6'd26: k = 32'hf4d50d87; 6'd27: k = 32'h455a14ed;
         6'd28: k = 32'ha9e3e905; 6'd29: k = 32'hfcefa3f8; 6'd30: k = 32'h676f02d9; 6'd31: k = 32'h8d2a4c8a;
         6'd32: k = 32'hfffa3942; 6'd33: k = 32'h8771f681; 6'd34: k = 32'h6d9d6122; 6'd35: k = 32'hfde5380c;
         6'd36: k = 32'ha4beea44; 6'd37: k = 32'h4bdecfa9; 6'd38: k = 32'hf6bb4b60; 6'd39: k = 32'hbebfbc70;
         6'd40: k = 32'h289b7ec6; 6'd41: k = 32'heaa127fa; 6'd42: k = 32'hd4ef3085; 6'd43: k = 32'h04881d05;
         6'd44: k = 32'hd9d4d039; 6'd45: k = 32'he6db99e5; 6'd46: k = 32'h1fa27cf8; 6'd47: k = 32'hc4ac5665;
         6'd48: k = 32'hf4292244; 6'd49: k = 32'h432aff97; 6'd50: k = 32'hab9423a7; 6'd51: k = 32'hfc93a039;
         6'd52: k = 32'h655b59c3; 6'd53: k = 32'h8f0ccc92; 6'd54: k = 32'hffeff47d; 6'd55: k = 32'h85845dd1;
         6'd56: k = 32'h6fa87e4f; 6'd57: k = 32'hfe2ce6e0; 6'd58: k = 32'ha3014314; 6'd59: k = 32'h4e0811a1;
         6'd60: k = 32'hf7537e82; 6'd61: k = 32'hbd3af235; 6'd62: k = 32'h2ad7d2bb; default: k = 32'heb86d391;
      endcase
      return k;
   endfunction

   // Shift amount depends only on the round group and i mod 4.
   function automatic logic [4:0] s_of(input logic [1:0] grp, input logic [1:0] sub);
      logic [4:0] s;
      case ({grp, sub})
         4'h0: s = 5'd7;  4'h1: s = 5'd12; 4'h2: s = 5'd17; 4'h3: s = 5'd22;
         4'h4: s = 5'd5;  4'h5: s = 5'd9;  4'h6: s = 5'd14; 4'h7: s = 5'd20;
         4'h8: s = 5'd4;  4'h9: s = 5'd11; 4'ha: s = 5'd16; 4'hb: s = 5'd23;
         4'hc: s = 5'd6;  4'hd: s = 5'd10; 4'he: s = 5'd15; default: s = 5'd21;
      endcase
      return s;
   endfunction

   function automatic logic [31:0] bswap(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   // Round datapath
   logic [3:0]  ii, g;
   logic [31:0] f, m_g, tmp, rot;
   logic [4:0]  s;

   always_comb begin
      ii = i_q[3:0];
      f  = 32'h0;
      g  = 4'h0;
      case (i_q[5:4])
         2'd0: begin f = (b_q & c_q) | (~b_q & d_q); g = ii;                 end
         2'd1: begin f = (d_q & b_q) | (~d_q & c_q); g = ii * 4'd5 + 4'd1;   end
         2'd2: begin f = b_q ^ c_q ^ d_q;            g = ii * 4'd3 + 4'd5;   end
         default: begin f = c_q ^ (b_q | ~d_q);      g = ii * 4'd7;          end
      endcase
      // Only M0/M1 carry data; padding and length words are constant.
      case (g)
         4'd0:    m_g = m0_q;
         4'd1:    m_g = m1_q;
         4'd2:    m_g = 32'h00000080;
         4'd14:   m_g = 32'h00000040;
         default: m_g = 32'h0;
      endcase
      s   = s_of(i_q[5:4], i_q[1:0]);
      tmp = a_q + f + k_of(i_q) + m_g;
      // s is never 0, so the right shift stays below 32.
      rot = (tmp << s) | (tmp >> (6'd32 - {1'b0, s}));
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      d_d     = d_q;
      m0_d    = m0_q;
      m1_d    = m1_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      hash_d  = hash_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               busy_d  = 1'b1;
               i_d     = 6'd0;
               a_d     = IV_A;
               b_d     = IV_B;
               c_d     = IV_C;
               d_d     = IV_D;
               // Little-endian word packing: first character is the low byte.
               m0_d    = {txt[39:32], txt[47:40], txt[55:48], txt[63:56]};
               m1_d    = {txt[7:0],   txt[15:8],  txt[23:16], txt[31:24]};
            end
         end
         S_RUN: begin
            a_d = d_q;
            d_d = c_q;
            c_d = b_q;
            b_d = b_q + rot;
            i_d = i_q + 6'd1;
            if (i_q == 6'd63) state_d = S_FIN;
         end
         default: begin
            hash_d  = {bswap(a_q + IV_A), bswap(b_q + IV_B),
                       bswap(c_q + IV_C), bswap(d_q + IV_D)};
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         i_q     <= 6'd0;
         a_q     <= 32'h0;
         b_q     <= 32'h0;
         c_q     <= 32'h0;
         d_q     <= 32'h0;
         m0_q    <= 32'h0;
         m1_q    <= 32'h0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hash_q  <= 128'h0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         m0_q    <= m0_d;
         m1_q    <= m1_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hash_q  <= hash_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hash = hash_q;

endmodule
